// File: rtl/sw_btn_debounce.sv
// -----------------------------------------------------------------------------
// sw_btn_debounce
//   Conditions raw board switches and buttons (speed select, reset button, ...)
//   before they reach the clock divider and CPU. Each channel is brought into
//   the clk domain by a 2-FF synchronizer and then filtered by its own
//   stability counter: a new level is accepted only after it has persisted for
//   STABLE_CNT consecutive clock cycles.
//
// Parameters
//   N_IN        number of independent input channels
//   CNT_W       width of each per-channel stability counter
//   STABLE_CNT  cycles a new level must persist (1 .. 2**CNT_W-1)
//
// Ports
//   clk     in   1     board clock, all logic on posedge
//   rst     in   1     asynchronous, active-high reset
//   raw_in  in   N_IN  unsynchronized switch/button levels
//   clean   out  N_IN  debounced level per channel
//   rise    out  N_IN  one-cycle pulse when clean[i] goes 0->1
//   fall    out  N_IN  one-cycle pulse when clean[i] goes 1->0
// -----------------------------------------------------------------------------
module sw_btn_debounce #(
  parameter int N_IN       = 16,
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall
);

  // Terminal count value: when the counter already holds this and the input
  // still differs, this cycle is the STABLE_CNT-th consecutive one.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

  if (STABLE_CNT < 1 || STABLE_CNT > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("sw_btn_debounce: STABLE_CNT out of range for CNT_W");
  end

  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;

  // Two-stage synchronizer; only sync2 is allowed to feed the filter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // One fully independent filter per channel.
  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;

    // NOTE: the counters are ordinary per-channel registers, so they take the
    // async reset too; a partial count must not survive a reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt      <= '0;
        clean[i] <= 1'b0;
        rise[i]  <= 1'b0;
        fall[i]  <= 1'b0;
      end else begin
        // Pulses default low; only an accepted transition raises one.
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (sync2[i] == clean[i]) begin
          // Input agrees with the accepted level: any glitch/bounce in
          // progress is discarded.
          cnt <= '0;
        end else if (cnt == LAST_CNT) begin
          clean[i] <= sync2[i];
          rise[i]  <= sync2[i];
          fall[i]  <= ~sync2[i];
          cnt      <= '0;
        end else begin
          // Cannot wrap: it is cleared on reaching LAST_CNT.
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_btn_debounce
//   Directed bench for sw_btn_debounce with N_IN=4, CNT_W=3, STABLE_CNT=4.
//   A raw change applied before edge k shows on clean after edge k+5, with the
//   matching rise/fall pulse high only in the cycle after that edge.
// -----------------------------------------------------------------------------
module tb_sw_btn_debounce;

  localparam int N_IN = 4;

  logic            clk;
  logic            rst;
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] clean;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;

  int total = 0;
  int bad   = 0;

  sw_btn_debounce #(
    .N_IN      (N_IN),
    .CNT_W     (3),
    .STABLE_CNT(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_in(raw_in),
    .clean (clean),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] clean;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [N_IN-1:0] act,
                       input logic [N_IN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [N_IN-1:0] raw,
                         input logic [N_IN-1:0] cl, input logic [N_IN-1:0] ri,
                         input logic [N_IN-1:0] fa);
    vecs[idx].raw   = raw;
    vecs[idx].clean = cl;
    vecs[idx].rise  = ri;
    vecs[idx].fall  = fa;
  endtask

  initial begin
    // Vector v: raw applied before edge v, outputs sampled after edge v.
    //   ch0 step:    raw 1 from v1            -> clean v6,  rise v6
    //   ch1 glitch:  raw 1 at v2..v4 (3 cyc)  -> never changes
    //   ch2 bounce:  1,0,1,0,1 at v3..v7, hold-> clean v12, rise v12
    //   ch3 release: raw 1 v0..v9, 0 from v10 -> clean v5..v14, rise v5, fall v15
    set_vec( 0, 4'h8, 4'h0, 4'h0, 4'h0);
    set_vec( 1, 4'h9, 4'h0, 4'h0, 4'h0);
    set_vec( 2, 4'hB, 4'h0, 4'h0, 4'h0);
    set_vec( 3, 4'hF, 4'h0, 4'h0, 4'h0);
    set_vec( 4, 4'hB, 4'h0, 4'h0, 4'h0);
    set_vec( 5, 4'hD, 4'h8, 4'h8, 4'h0);
    set_vec( 6, 4'h9, 4'h9, 4'h1, 4'h0);
    set_vec( 7, 4'hD, 4'h9, 4'h0, 4'h0);
    set_vec( 8, 4'hD, 4'h9, 4'h0, 4'h0);
    set_vec( 9, 4'hD, 4'h9, 4'h0, 4'h0);
    set_vec(10, 4'h5, 4'h9, 4'h0, 4'h0);
    set_vec(11, 4'h5, 4'h9, 4'h0, 4'h0);
    set_vec(12, 4'h5, 4'hD, 4'h4, 4'h0);
    set_vec(13, 4'h5, 4'hD, 4'h0, 4'h0);
    set_vec(14, 4'h5, 4'hD, 4'h0, 4'h0);
    set_vec(15, 4'h5, 4'h5, 4'h0, 4'h8);
    set_vec(16, 4'h5, 4'h5, 4'h0, 4'h0);
    set_vec(17, 4'h5, 4'h5, 4'h0, 4'h0);

    // Reset acts immediately, before any clock edge.
    rst    = 1'b0;
    raw_in = 4'hF;
    #2 rst = 1'b1;
    #1;
    check("reset_clean", clean, 4'h0);
    check("reset_rise",  rise,  4'h0);
    check("reset_fall",  fall,  4'h0);

    // Still cleared across edges while held, even with raw_in all high.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_clean", clean, 4'h0);
    check("reset_hold_rise",  rise,  4'h0);

    raw_in = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 18; v++) begin
      @(negedge clk) raw_in = vecs[v].raw;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_clean", v), clean, vecs[v].clean);
      check($sformatf("v%0d_rise",  v), rise,  vecs[v].rise);
      check($sformatf("v%0d_fall",  v), fall,  vecs[v].fall);
    end

    // Reset mid-count: clear everything, start a ch0 count, reset two edges in.
    @(negedge clk) begin
      rst    = 1'b1;
      raw_in = 4'h0;
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) raw_in = 4'h1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_clean", clean, 4'h0);
    @(posedge clk);
    #1;
    check("midrst_hold_clean", clean, 4'h0);
    check("midrst_hold_rise",  rise,  4'h0);
    @(negedge clk) rst = 1'b0;
    // First edge after release is edge 1; clean rises at edge 6.
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_e%0d_clean", e), clean, (e >= 6) ? 4'h1 : 4'h0);
      check($sformatf("post_rst_e%0d_rise",  e), rise,  (e == 6) ? 4'h1 : 4'h0);
      check($sformatf("post_rst_e%0d_fall",  e), fall,  4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
